// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low matrix keypad scanner with frame debounce.
// Optional auto-repeat of the held key is enabled by `define KEY_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 20000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_FRAMES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DS_L     = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] divider;
    logic [1:0]    col_idx;
    logic [1:0]    col_next;
    logic [15:0]   map;
    logic          tick;
    logic          frame_done;

    assign tick     = (divider == DIV_LAST);
    assign col_next = col_idx + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta   <= 4'b1111;
            row_sync   <= 4'b1111;
            divider    <= '0;
            col_idx    <= 2'd0;
            col        <= 4'b1110;
            map        <= '0;
            frame_done <= 1'b0;
        end else begin
            row_meta   <= row;
            row_sync   <= row_meta;
            frame_done <= tick && (col_idx == 2'd3);
            divider    <= tick ? '0 : divider + 1'b1;
            if (tick) begin
                // A low row means the key at (col_idx, row) is closed.
                case (col_idx)
                    2'd0:    map[3:0]   <= ~row_sync;
                    2'd1:    map[7:4]   <= ~row_sync;
                    2'd2:    map[11:8]  <= ~row_sync;
                    default: map[15:12] <= ~row_sync;
                endcase
                col_idx <= col_next;
                col     <= ~(4'b0001 << col_next);
            end else if (frame_done) begin
                map <= '0;
            end
        end
    end

    logic       hit_any;
    logic       hit_multi;
    logic [3:0] hit_idx;
    logic       frame_none;
    logic       frame_one;

    always_comb begin
        hit_any   = 1'b0;
        hit_multi = 1'b0;
        hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (map[i]) begin
                if (hit_any) hit_multi = 1'b1;
                hit_any = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    assign frame_none = !hit_any;
    assign frame_one  = hit_any && !hit_multi;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic [3:0]    code_n;
    logic          valid_n;
    logic          down_n;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] RP_L = RW'(REPEAT_FRAMES);
    logic [RW-1:0] rep_cnt, rep_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_cnt <= '0;
        else     rep_cnt <= rep_n;
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_FRAMES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        valid_n = 1'b0;
        down_n  = key_down;
`ifdef KEY_REPEAT_EN
        rep_n   = rep_cnt;
`endif
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (frame_one) begin
                        cand_n = hit_idx;
                        cnt_n  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n = PRESSED;
                            code_n  = hit_idx;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
`ifdef KEY_REPEAT_EN
                            rep_n   = '0;
`endif
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (frame_one && (hit_idx == cand)) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == DS_L) begin
                            state_n = PRESSED;
                            code_n  = cand;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
`ifdef KEY_REPEAT_EN
                            rep_n   = '0;
`endif
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (frame_none) begin
                        cnt_n = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n = IDLE;
                            down_n  = 1'b0;
                        end else begin
                            state_n = RELEASE;
                        end
`ifdef KEY_REPEAT_EN
                        rep_n = '0;
                    end else if (frame_one && (hit_idx == key_code)) begin
                        rep_n = rep_cnt + 1'b1;
                        if (rep_n == RP_L) begin
                            valid_n = 1'b1;
                            rep_n   = '0;
                        end
                    end else begin
                        rep_n = '0;
`endif
                    end
                end
                default: begin
                    // Any closure during release debounce means the key is still held.
                    if (frame_none) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == DS_L) begin
                            state_n = IDLE;
                            down_n  = 1'b0;
                        end
                    end else begin
                        state_n = PRESSED;
`ifdef KEY_REPEAT_EN
                        rep_n   = '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule
